axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Round-robin arbiter that shares one AXI-Stream sink, normally the input of a `fifo`, among NUM_INPUTS AXI-Stream sources. Each grant holds for at most MAX_BURST beats before the grant rotates. The block forwards the granted source combinationally to the master port and tags each beat with the source index. It sits in front of the shared FIFO chain and also lets software mask sources out of arbitration.

## Interface
- WIDTH, 32: tdata width per stream.
- NUM_INPUTS, 4: number of source streams, 2..16.
- ID_WIDTH, 2: width of m_axis_tid; must equal ceil(log2(NUM_INPUTS)).
- MAX_BURST, 4: maximum beats per grant, 1..255.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- en_mask  in  NUM_INPUTS  bit i=1 allows source i to win arbitration.
- s_axis_tdata  in  NUM_INPUTS*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH].
- s_axis_tvalid  in  NUM_INPUTS  per-source valid.
- s_axis_tready  out  NUM_INPUTS  per-source ready.
- m_axis_tdata  out  WIDTH  forwarded data.
- m_axis_tvalid  out  1  forwarded valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tid  out  ID_WIDTH  index of the granted source.
- busy  out  1  high while in GRANT.

## Operation
- Reset (aresetn=0 at a rising edge):
  - state=IDLE, grant=0, last=NUM_INPUTS-1, beat count=0.
  - Outputs while in reset: m_axis_tvalid=0, s_axis_tready=0, m_axis_tid=0, busy=0.
- The FSM has two states, IDLE and GRANT.
- IDLE:
  - All s_axis_tready=0, m_axis_tvalid=0.
  - req = s_axis_tvalid & en_mask.
  - If req≠0: choose the first set bit scanning last+1, last+2, … modulo NUM_INPUTS. Register it into grant, clear count, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - m_axis_tdata = s_axis_tdata[grant].
  - m_axis_tvalid = s_axis_tvalid[grant].
  - m_axis_tid = grant.
  - s_axis_tready[grant] = m_axis_tready; all other readies are 0.
  - A beat transfers when s_axis_tvalid[grant] & m_axis_tready; count increments on each beat.
  - Burst limit: a beat at count==MAX_BURST-1 ends the grant. Set last=grant and go to IDLE.
  - Source drain: s_axis_tvalid[grant]=0 ends the grant in that cycle. Set last=grant and go to IDLE; no beat transfers.
  - If both conditions coincide, the outcome is identical (IDLE, last=grant).
- en_mask is sampled only in IDLE. Clearing a mask bit mid-grant does not end the current grant.
- m_axis_tid holds the last grant value while in IDLE.
- Data is never duplicated, dropped or reordered within a source.
- Each source is blocked for at most (NUM_INPUTS-1)*(MAX_BURST+1) grant-cycles of other traffic, plus sink stalls.

## Timing
- Arbitration latency: source tvalid rising in cycle n (block in IDLE) gives m_axis_tvalid=1 in cycle n+1.
- Datapath is combinational in GRANT: zero latency from s_axis_* to m_axis_*, and from m_axis_tready to s_axis_tready.
- Every grant is followed by exactly one IDLE cycle, even when the same source is the only requester. Peak throughput under continuous demand is MAX_BURST/(MAX_BURST+1).
- Sink stall (m_axis_tready=0) holds grant and count indefinitely. m_axis_tdata/tvalid then follow the source, which must hold them per AXI-Stream rules.
- Reset mid-burst: the next cycle is IDLE with last=NUM_INPUTS-1. Beats not yet handshaken are not lost from the source's view, because tready was 0 or the handshake had not occurred.

## Test plan
- Single source: after reset, source 0 sends 0..9 continuously, sink always ready, MAX_BURST=4.
  - Required: m_axis_tdata 0..9 in order, m_axis_tid=0.
  - Required: IDLE gaps after beats 3 and 7; 12 cycles total from first m_axis_tvalid.
- Round-robin rotation: sources 0..3 all valid, source i sending i*100+k.
  - Required: tid sequence 0,0,0,0,1,1,1,1,2,…,3,0.
  - Required: each burst has k=0..3 then 4..7.
- Early release: source 2 presents 2 beats then drops tvalid while source 1 waits.
  - Required: source 2's burst ends after 2 beats; next grant is 3 if valid, else 0, else 1 (scan from last=2).
- Mask and stall: en_mask=4'b1101 with all sources valid.
  - Required: source 1 is never granted.
  - With sink tready=0 for 7 cycles mid-burst: count frozen, no beat lost.
  - Clearing en_mask[0] during source 0's grant does not cut that burst.
- Integration with two chained `fifo` DEPTH=5 and sink stalled:
  - Arbiter fills both FIFOs until backpressure reaches it.
  - Then sink ready: drained data matches per-source order, and total beats received equals total sent.
- Reset mid-burst: assert aresetn=0 at beat 2 of source 1's grant.
  - Required next cycle: m_axis_tvalid=0, busy=0, all s_axis_tready=0.
  - First grant after release goes to the lowest-index valid source.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter_if
// Bundles the AXI-Stream signals of the round-robin arbiter: NUM_INPUTS source
// streams on the s_axis_* side and one shared sink on the m_axis_* side.
//
//   s_axis_tdata   NUM_INPUTS*WIDTH  source data, source i at [i*WIDTH +: WIDTH]
//   s_axis_tvalid  NUM_INPUTS        per-source valid
//   s_axis_tready  NUM_INPUTS        per-source ready
//   m_axis_tdata   WIDTH             forwarded data
//   m_axis_tvalid  1                 forwarded valid
//   m_axis_tready  1                 sink ready
//   m_axis_tid     ID_WIDTH          index of the granted source
//
// Modports:
//   slave  - the arbiter's view (consumes sources, drives the sink)
//   master - the environment's view (drives sources, consumes the sink)
// ---------------------------------------------------------------------------
interface axis_rr_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 32,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_INPUTS*WIDTH-1:0] s_axis_tdata;
    logic [NUM_INPUTS-1:0]       s_axis_tvalid;
    logic [NUM_INPUTS-1:0]       s_axis_tready;
    logic [WIDTH-1:0]            m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [ID_WIDTH-1:0]         m_axis_tid;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
// Round-robin arbiter sharing one AXI-Stream sink among NUM_INPUTS sources.
// A grant lasts at most MAX_BURST beats or until the granted source drops
// tvalid, and is always followed by one IDLE arbitration cycle. The granted
// source is forwarded combinationally and each beat is tagged with its index.
//
// Ports:
//   aclk     in   clock, rising edge
//   aresetn  in   synchronous active-low reset
//   en_mask  in   bit i=1 allows source i to win arbitration (sampled in IDLE)
//   axis     slave modport of axis_rr_arbiter_if (sources + shared sink)
//   busy     out  high while a grant is active
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NUM_INPUTS-1:0] en_mask,
    axis_rr_arbiter_if.slave      axis,
    output logic                  busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_INPUTS - 1);
    localparam logic [7:0]          BURST_END = 8'(MAX_BURST - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   w_grant_next;
    logic [ID_WIDTH-1:0]   r_last;
    logic [ID_WIDTH-1:0]   w_last_next;
    logic [7:0]            r_count;
    logic [7:0]            w_count_next;

    logic [NUM_INPUTS-1:0] w_req;
    logic [ID_WIDTH-1:0]   w_scan_idx;
    logic [ID_WIDTH-1:0]   w_pick;
    logic                  w_pick_ok;
    logic                  w_src_valid;
    logic [WIDTH-1:0]      w_src_data;
    logic                  w_beat;
    logic                  w_active;

    assign w_req = axis.s_axis_tvalid & en_mask;

    // Rotating-priority scan: the source after the last winner has top priority,
    // the last winner itself comes last.
    // NOTE: every signal assigned in a combinational block gets a default at the
    // top; a path that skips the assignment would otherwise infer a latch.
    always_comb begin
        w_pick     = '0;
        w_pick_ok  = 1'b0;
        w_scan_idx = '0;
        for (int off = 1; off <= NUM_INPUTS; off++) begin
            w_scan_idx = ID_WIDTH'((int'(r_last) + off) % NUM_INPUTS);
            if (!w_pick_ok && w_req[w_scan_idx]) begin
                w_pick    = w_scan_idx;
                w_pick_ok = 1'b1;
            end
        end
    end

    // Granted-source mux and ready steering. Outputs are forced inactive while
    // aresetn is low so the sink never sees a beat during reset.
    assign w_active = (r_state == ST_GRANT) && aresetn;

    always_comb begin
        w_src_valid        = 1'b0;
        w_src_data         = '0;
        axis.s_axis_tready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant == ID_WIDTH'(i)) begin
                w_src_valid           = axis.s_axis_tvalid[i];
                w_src_data            = axis.s_axis_tdata[i*WIDTH +: WIDTH];
                axis.s_axis_tready[i] = w_active && axis.m_axis_tready;
            end
        end
    end

    assign w_beat             = w_src_valid && axis.m_axis_tready;
    assign axis.m_axis_tdata  = w_src_data;
    assign axis.m_axis_tvalid = w_active && w_src_valid;
    assign axis.m_axis_tid    = aresetn ? r_grant : '0;
    assign busy               = w_active;

    // Next-state logic. A grant ends either on the last beat of the burst or
    // as soon as the granted source stops presenting data; both return to IDLE
    // and move the round-robin pointer to the finished source.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_ok) begin
                    w_state_next = ST_GRANT;
                    w_grant_next = w_pick;
                    w_count_next = '0;
                end
            end
            ST_GRANT: begin
                if (!w_src_valid || (w_beat && (r_count == BURST_END))) begin
                    w_state_next = ST_IDLE;
                    w_last_next  = r_grant;
                end else if (w_beat) begin
                    w_count_next = r_count + 8'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= LAST_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed bench for axis_rr_arbiter (NUM_INPUTS=4, WIDTH=32, MAX_BURST=4).
// A per-cycle vector table covers single-source timing; multi-cycle scenarios
// use simple AXI-Stream source counters and compare the received beat log
// against hand-derived sequences.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int MB  = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [N-1:0]  en_mask;
    logic          busy;

    axis_rr_arbiter_if #(.NUM_INPUTS(N), .WIDTH(W), .ID_WIDTH(IDW)) axis ();

    axis_rr_arbiter #(
        .WIDTH(W), .NUM_INPUTS(N), .ID_WIDTH(IDW), .MAX_BURST(MB)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en_mask (en_mask),
        .axis    (axis.slave),
        .busy    (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        rdy;
        logic        exp_mv;
        logic [31:0] exp_data;
        logic [1:0]  exp_tid;
        logic        exp_busy;
        logic [3:0]  exp_rdy;
    } vec_t;

    typedef struct {
        logic [1:0]  tid;
        logic [31:0] data;
    } beat_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    vec_t   vecs[15];
    beat_t  log_q[$];
    beat_t  exp_q[$];
    int     cnt[N];
    int     lim[N];
    logic [N-1:0] mask_a, mask_b;
    int     mask_switch;
    int     ready_mode;
    int     stall_start, stall_len, cap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r,
                                input logic mv, input logic [31:0] ed, input logic [1:0] et,
                                input logic eb, input logic [3:0] er);
        vec_t x;
        x.v0 = v; x.d0 = d; x.rdy = r;
        x.exp_mv = mv; x.exp_data = ed; x.exp_tid = et; x.exp_busy = eb; x.exp_rdy = er;
        return x;
    endfunction

    task automatic do_reset();
        aresetn            = 1'b0;
        en_mask            = '1;
        axis.s_axis_tvalid = '0;
        axis.s_axis_tdata  = '0;
        axis.m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("reset tvalid", 32'(axis.m_axis_tvalid), 32'd0);
        check("reset busy",   32'(busy),               32'd0);
        check("reset tready", 32'(axis.s_axis_tready), 32'd0);
        check("reset tid",    32'(axis.m_axis_tid),    32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        log_q.delete();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            lim[i] = 0;
        end
        mask_a      = '1;
        mask_b      = '1;
        mask_switch = 1000;
        ready_mode  = 0;
    endtask

    // Source i presents i*100+cnt[i] while cnt[i] < lim[i]; cnt advances on
    // each handshake. Beats accepted by the sink are appended to log_q.
    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            en_mask = (c < mask_switch) ? mask_a : mask_b;
            for (int i = 0; i < N; i++) begin
                axis.s_axis_tvalid[i]          = (cnt[i] < lim[i]);
                axis.s_axis_tdata[i*W +: W]    = 32'(i*100 + cnt[i]);
            end
            case (ready_mode)
                1:       axis.m_axis_tready = !((c >= stall_start) && (c < stall_start + stall_len));
                2:       axis.m_axis_tready = (log_q.size() < cap);
                default: axis.m_axis_tready = 1'b1;
            endcase
            @(negedge aclk);
            if (axis.m_axis_tvalid && axis.m_axis_tready)
                log_q.push_back('{tid: axis.m_axis_tid, data: axis.m_axis_tdata});
            for (int i = 0; i < N; i++)
                if (axis.s_axis_tready[i] && axis.s_axis_tvalid[i]) cnt[i]++;
            @(posedge aclk); #1;
        end
    endtask

    task automatic compare_log(input string name);
        int sum;
        sum = 0;
        for (int i = 0; i < N; i++) sum += cnt[i];
        check({name, " beats sent vs received"}, 32'(sum), 32'(log_q.size()));
        check({name, " log size"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s beat%0d tid", name, i),  32'(log_q[i].tid), 32'(exp_q[i].tid));
            check($sformatf("%s beat%0d data", name, i), log_q[i].data,     exp_q[i].data);
        end
    endtask

    task automatic exp_burst(input int s, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++)
            exp_q.push_back('{tid: 2'(s), data: 32'(s*100 + k)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single source, 10 beats, MAX_BURST=4: bursts 0-3, 4-7, 8-9 then drain.
        vecs[0]  = mk(1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0, 4'b0000);
        vecs[1]  = mk(1'b1, 32'd0, 1'b1, 1'b1, 32'd0, 2'd0, 1'b1, 4'b0001);
        vecs[2]  = mk(1'b1, 32'd1, 1'b1, 1'b1, 32'd1, 2'd0, 1'b1, 4'b0001);
        vecs[3]  = mk(1'b1, 32'd2, 1'b1, 1'b1, 32'd2, 2'd0, 1'b1, 4'b0001);
        vecs[4]  = mk(1'b1, 32'd3, 1'b1, 1'b1, 32'd3, 2'd0, 1'b1, 4'b0001);
        vecs[5]  = mk(1'b1, 32'd4, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0, 4'b0000);
        vecs[6]  = mk(1'b1, 32'd4, 1'b1, 1'b1, 32'd4, 2'd0, 1'b1, 4'b0001);
        vecs[7]  = mk(1'b1, 32'd5, 1'b1, 1'b1, 32'd5, 2'd0, 1'b1, 4'b0001);
        vecs[8]  = mk(1'b1, 32'd6, 1'b1, 1'b1, 32'd6, 2'd0, 1'b1, 4'b0001);
        vecs[9]  = mk(1'b1, 32'd7, 1'b1, 1'b1, 32'd7, 2'd0, 1'b1, 4'b0001);
        vecs[10] = mk(1'b1, 32'd8, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0, 4'b0000);
        vecs[11] = mk(1'b1, 32'd8, 1'b1, 1'b1, 32'd8, 2'd0, 1'b1, 4'b0001);
        vecs[12] = mk(1'b1, 32'd9, 1'b1, 1'b1, 32'd9, 2'd0, 1'b1, 4'b0001);
        vecs[13] = mk(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1, 4'b0001);
        vecs[14] = mk(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b0, 4'b0000);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            axis.s_axis_tvalid = {3'b000, vecs[i].v0};
            axis.s_axis_tdata  = '0;
            axis.s_axis_tdata[31:0] = vecs[i].d0;
            axis.m_axis_tready = vecs[i].rdy;
            @(negedge aclk);
            check($sformatf("single[%0d] tvalid", i), 32'(axis.m_axis_tvalid), 32'(vecs[i].exp_mv));
            check($sformatf("single[%0d] tid", i),    32'(axis.m_axis_tid),    32'(vecs[i].exp_tid));
            check($sformatf("single[%0d] busy", i),   32'(busy),               32'(vecs[i].exp_busy));
            check($sformatf("single[%0d] tready", i), 32'(axis.s_axis_tready), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_mv)
                check($sformatf("single[%0d] tdata", i), axis.m_axis_tdata, vecs[i].exp_data);
            @(posedge aclk); #1;
        end

        // Round-robin rotation, all sources valid, two rounds of full bursts.
        do_reset();
        for (int i = 0; i < N; i++) lim[i] = 8;
        run(48);
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) exp_burst(s, r*4, 4);
        compare_log("rotation");

        // Early release: source 2 sends 2 beats then drops; only source 1 waits.
        do_reset();
        lim[1] = 3; lim[2] = 2;
        mask_a = 4'b0100; mask_b = 4'b1111; mask_switch = 1;
        run(14);
        exp_q.delete();
        exp_burst(2, 0, 2); exp_burst(1, 0, 3);
        compare_log("release_1");

        // Early release with sources 0 and 1 waiting: 0 precedes 1.
        do_reset();
        lim[0] = 1; lim[1] = 1; lim[2] = 2;
        mask_a = 4'b0100; mask_b = 4'b1111; mask_switch = 1;
        run(16);
        exp_q.delete();
        exp_burst(2, 0, 2); exp_burst(0, 0, 1); exp_burst(1, 0, 1);
        compare_log("release_01");

        // Early release with 3, 0 and 1 waiting: scan from last=2 gives 3, 0, 1.
        do_reset();
        lim[0] = 1; lim[1] = 1; lim[2] = 2; lim[3] = 1;
        mask_a = 4'b0100; mask_b = 4'b1111; mask_switch = 1;
        run(18);
        exp_q.delete();
        exp_burst(2, 0, 2); exp_burst(3, 0, 1); exp_burst(0, 0, 1); exp_burst(1, 0, 1);
        compare_log("release_301");

        // Mask 1101 with a 7-cycle sink stall inside source 0's first burst.
        do_reset();
        for (int i = 0; i < N; i++) lim[i] = 8;
        mask_a = 4'b1101; mask_b = 4'b1101;
        ready_mode = 1; stall_start = 2; stall_len = 7;
        run(50);
        exp_q.delete();
        for (int r = 0; r < 2; r++) begin
            exp_burst(0, r*4, 4); exp_burst(2, r*4, 4); exp_burst(3, r*4, 4);
        end
        compare_log("mask_stall");
        check("mask_stall source1 beats", 32'(cnt[1]), 32'd0);

        // Clearing en_mask[0] during source 0's grant keeps the full burst.
        do_reset();
        for (int i = 0; i < N; i++) lim[i] = 4;
        mask_a = 4'b1111; mask_b = 4'b1110; mask_switch = 2;
        run(25);
        exp_q.delete();
        for (int s = 0; s < N; s++) exp_burst(s, 0, 4);
        compare_log("mask_clear");

        // Two chained 5-deep FIFOs with stalled output: 10 slots, then drain.
        do_reset();
        for (int i = 0; i < N; i++) lim[i] = 5;
        ready_mode = 2; cap = 10;
        run(30);
        begin
            int sum;
            sum = 0;
            for (int i = 0; i < N; i++) sum += cnt[i];
            check("fifo fill level", 32'(log_q.size()), 32'd10);
            check("fifo sent while full", 32'(sum), 32'd10);
            check("fifo backpressure busy", 32'(busy), 32'd1);
        end
        ready_mode = 0;
        run(40);
        check("fifo total received", 32'(log_q.size()), 32'(4*5));
        for (int s = 0; s < N; s++) begin
            int k;
            k = 0;
            for (int i = 0; i < log_q.size(); i++) begin
                if (log_q[i].tid == 2'(s)) begin
                    check($sformatf("fifo src%0d order%0d", s, k), log_q[i].data, 32'(s*100 + k));
                    k++;
                end
            end
            check($sformatf("fifo src%0d count", s), 32'(k), 32'd5);
        end

        // Reset at beat 2 of source 1's grant.
        do_reset();
        en_mask = 4'b1111;
        axis.s_axis_tvalid = 4'b0110;
        axis.s_axis_tdata  = '0;
        axis.s_axis_tdata[1*W +: W] = 32'd100;
        axis.s_axis_tdata[2*W +: W] = 32'd200;
        axis.m_axis_tready = 1'b1;
        @(negedge aclk);
        check("rst_mid idle busy", 32'(busy), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("rst_mid grant tid", 32'(axis.m_axis_tid), 32'd1);
        check("rst_mid grant tvalid", 32'(axis.m_axis_tvalid), 32'd1);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(negedge aclk);
        check("rst_mid in-reset tvalid", 32'(axis.m_axis_tvalid), 32'd0);
        check("rst_mid in-reset tready", 32'(axis.s_axis_tready), 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        axis.s_axis_tvalid = 4'b0111;
        @(negedge aclk);
        check("rst_mid after tvalid", 32'(axis.m_axis_tvalid), 32'd0);
        check("rst_mid after busy",   32'(busy),               32'd0);
        check("rst_mid after tready", 32'(axis.s_axis_tready), 32'd0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("rst_mid first grant tid", 32'(axis.m_axis_tid), 32'd0);
        check("rst_mid first grant busy", 32'(busy), 32'd1);
        check("rst_mid first grant tvalid", 32'(axis.m_axis_tvalid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
